// File: rtl/fifo_access_scheduler.sv
// Shares one small sync FIFO between two producers (round-robin write arbiter)
// and drains it in bursts. Note: rst_n is an active-high synchronous reset.
module fifo_access_scheduler #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_rd_en,
  input  logic              drain_req,
  input  logic [LEN_W-1:0]  drain_len,
  input  logic              drain_abort,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   remaining, remaining_nxt;
  logic               last_grant;
  logic               grant0, grant1;
  logic               rd_issue, done_c;
  logic               vld_p1;
  logic [DATA_W-1:0]  data_p1;

  // Write arbiter: requester 1 wins when alone, or on a tie when 0 went last.
  always_comb begin
    grant1 = ~rst_n & req1_valid & (~req0_valid | ~last_grant);
    grant0 = ~rst_n & req0_valid & ~grant1;
  end

  assign req0_ready = grant0 & ~fifo_full;
  assign req1_ready = grant1 & ~fifo_full;
  assign fifo_wr_en = req0_ready | req1_ready;
  assign fifo_wdata = grant0 ? req0_data : (grant1 ? req1_data : '0);

  // The pointer only rotates on an accepted write, so a full stall keeps its grant.
  always_ff @(posedge clk) begin
    if (rst_n)
      last_grant <= 1'b1;
    else if (fifo_wr_en)
      last_grant <= grant1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    rd_issue      = 1'b0;
    done_c        = 1'b0;
    case (state)
      IDLE: begin
        if (drain_req && (drain_len != '0)) begin
          remaining_nxt = drain_len;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        if (drain_abort) begin
          remaining_nxt = '0;
          state_nxt     = FLUSH;
        end else if (!fifo_empty && (remaining != '0)) begin
          rd_issue      = 1'b1;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1))
            state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = rd_issue & ~rst_n;
  assign done       = done_c & ~rst_n;
  assign busy       = ~rst_n & (state != IDLE);

  // Stage p1: read issued last cycle, FIFO data is on fifo_rdata now.
  always_ff @(posedge clk) begin
    if (rst_n)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      data_p1 <= '0;
    else if (vld_p1)
      data_p1 <= fifo_rdata;
  end

  assign out_valid = vld_p1 & ~rst_n;
  assign out_data  = rst_n ? '0 : (out_valid ? fifo_rdata : data_p1);

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a behavioural 16-deep FIFO and
// a scoreboard of expected drained words.
module tb_fifo_access_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       fifo_full, fifo_empty;
  logic [3:0] fifo_rdata;
  logic       fifo_wr_en, fifo_rd_en;
  logic [3:0] fifo_wdata;
  logic       drain_req = 1'b0, drain_abort = 1'b0;
  logic [2:0] drain_len = '0;
  logic       out_valid, busy, done;
  logic [3:0] out_data;

  logic       force_full = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int n_words  = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_access_scheduler #(.DATA_W(4), .LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_rd_en(fifo_rd_en),
    .drain_req(drain_req), .drain_len(drain_len), .drain_abort(drain_abort),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  // Behavioural FIFO: read data registered, valid the cycle after fifo_rd_en.
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_full  = force_full | (cnt == 5'd16);

  always @(posedge clk) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (fifo_wr_en) begin
        mem[wp] <= fifo_wdata;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd_en) begin
        fifo_rdata <= mem[rp];
        rp         <= rp + 4'd1;
      end
      cnt <= cnt + 5'(fifo_wr_en) - 5'(fifo_rd_en);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output monitor: every out_valid pulse pops one expected word.
  always begin
    @(negedge clk);
    #3;
    if (out_valid === 1'b1) begin
      n_words++;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL out_extra: observed word %0h expected none", out_data);
      end else begin
        check("out_data", {4'h0, out_data}, {4'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Test 1: reset state, then a single write from producer 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ctrl", {req0_ready, req1_ready, fifo_wr_en, fifo_rd_en, out_valid, busy, done, 1'b0}, 8'h00);
    check("rst_wdata", {4'h0, fifo_wdata}, 8'h00);
    check("rst_odata", {4'h0, out_data}, 8'h00);
    req0_valid = 1'b1; req0_data = 4'hA;
    #1;
    check("rst_blocks_wr", {6'h0, req0_ready, fifo_wr_en}, 8'h00);
    @(negedge clk);
    rst_n = 1'b0; clr = 1'b0;
    #1;
    check("t1_ready", {6'h0, req0_ready, req1_ready}, 8'h02);
    check("t1_wr_en", {7'h0, fifo_wr_en}, 8'h01);
    check("t1_wdata", {4'h0, fifo_wdata}, 8'h0A);

    // Test 2: both valid after a fresh reset alternate 3,C,3,C
    @(negedge clk);
    req0_valid = 1'b0; rst_n = 1'b1;
    #1;
    check("t2_rst_wr", {7'h0, fifo_wr_en}, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 4'h3;
    req1_valid = 1'b1; req1_data = 4'hC;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("t2_wdata", {4'h0, fifo_wdata}, (i % 2 == 0) ? 8'h03 : 8'h0C);
      check("t2_ready", {6'h0, req0_ready, req1_ready}, (i % 2 == 0) ? 8'h02 : 8'h01);
      check("t2_wr_en", {7'h0, fifo_wr_en}, 8'h01);
    end

    // Test 3: full stalls both, pointer holds, release gives same grant
    @(negedge clk);
    force_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("t3_full_blk", {5'h0, req0_ready, req1_ready, fifo_wr_en}, 8'h00);
    end
    @(negedge clk);
    force_full = 1'b0;
    #1;
    check("t3_release", {6'h0, req0_ready, req1_ready}, 8'h02);
    check("t3_rel_data", {4'h0, fifo_wdata}, 8'h03);
    @(negedge clk);
    #1;
    check("t3_rotate", {6'h0, req0_ready, req1_ready}, 8'h01);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // Test 4: FIFO holds A,C, burst of 2
    req0_valid = 1'b1; req0_data = 4'hA; exp_q.push_back(4'hA);
    @(negedge clk);
    req0_data = 4'hC; exp_q.push_back(4'hC);
    @(negedge clk);
    req0_valid = 1'b0; drain_req = 1'b1; drain_len = 3'd2;
    #1;
    check("t4_idle_busy", {7'h0, busy}, 8'h00);
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    check("t4_rd1", {6'h0, fifo_rd_en, busy}, 8'h03);
    @(negedge clk);
    #1;
    check("t4_rd2", {7'h0, fifo_rd_en}, 8'h01);
    @(negedge clk);
    #1;
    check("t4_flush", {5'h0, done, fifo_rd_en, busy}, 8'h05);
    @(negedge clk);
    #1;
    check("t4_idle", {6'h0, busy, done}, 8'h00);

    // Test 5: len 3 with one word, stall on empty, then refill
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 4'h5; exp_q.push_back(4'h5);
    @(negedge clk);
    req1_valid = 1'b0; drain_req = 1'b1; drain_len = 3'd3;
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    check("t5_rd_first", {7'h0, fifo_rd_en}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t5_stall", {6'h0, fifo_rd_en, busy}, 8'h01);
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 4'h6; exp_q.push_back(4'h6);
    #1;
    check("t5_wr_empty", {6'h0, fifo_rd_en, req0_ready}, 8'h01);
    @(negedge clk);
    req0_data = 4'h9; exp_q.push_back(4'h9);
    #1;
    check("t5_wr_and_rd", {6'h0, fifo_rd_en, fifo_wr_en}, 8'h03);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("t5_rd_last", {7'h0, fifo_rd_en}, 8'h01);
    @(negedge clk);
    #1;
    check("t5_done", {7'h0, done}, 8'h01);
    @(negedge clk);
    #1;
    check("t5_idle", {6'h0, busy, done}, 8'h00);

    // Test 6: abort after one issue of a len-4 burst
    req0_valid = 1'b1; req0_data = 4'h1; exp_q.push_back(4'h1);
    @(negedge clk); req0_data = 4'h2;
    @(negedge clk); req0_data = 4'h3;
    @(negedge clk); req0_data = 4'h4;
    @(negedge clk);
    req0_valid = 1'b0; drain_req = 1'b1; drain_len = 3'd4;
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    check("t6_rd1", {7'h0, fifo_rd_en}, 8'h01);
    @(negedge clk);
    drain_abort = 1'b1;
    #1;
    check("t6_abort", {6'h0, fifo_rd_en, busy}, 8'h01);
    @(negedge clk);
    drain_abort = 1'b0;
    #1;
    check("t6_abort_done", {6'h0, done, fifo_rd_en}, 8'h02);
    @(negedge clk);
    #1;
    check("t6_idle", {6'h0, busy, done}, 8'h00);

    // Zero-length request is ignored
    @(negedge clk);
    drain_req = 1'b1; drain_len = 3'd0;
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    check("len0_ignored", {6'h0, busy, fifo_rd_en}, 8'h00);

    // Reset mid-RUN: issued word dropped, no done
    @(negedge clk);
    drain_req = 1'b1; drain_len = 3'd2;
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    check("t6b_rd", {7'h0, fifo_rd_en}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6b_rst_outs", {4'h0, out_valid, busy, done, fifo_rd_en}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b0;
      #1;
      check("t6b_after_rst", {5'h0, busy, done, out_valid}, 8'h00);
    end

    @(negedge clk);
    #1;
    check("sb_empty", 8'(exp_q.size()), 8'h00);
    check("sb_words", 8'(n_words), 8'h06);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
